// File: rtl/uart_reg_slave.sv
// UART command responder: decodes write/read command frames from the host master,
// drives a simple register port and returns read data as a UART frame.
module uart_reg_slave #(
    parameter int unsigned BR           = 434,
    parameter int unsigned TURN_BITS    = 2,
    parameter int unsigned TIMEOUT_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_en,
    output logic [6:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       err
);

    localparam int unsigned HALF     = BR / 2;
    localparam int unsigned TURN_CYC = TURN_BITS * BR;
    localparam int unsigned TMO_CYC  = TIMEOUT_BITS * BR;
    localparam int unsigned CMAX     = (TURN_CYC > BR) ? TURN_CYC : BR;
    localparam int          CW       = $clog2(CMAX + 1);
    localparam int          TW       = $clog2(TMO_CYC + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_START,
        S_RX_DATA,
        S_RX_PAR,
        S_RX_STOP,
        S_WAIT2,
        S_TURN,
        S_TX
    } state_t;

    state_t          state_q;
    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   tmo_q;
    logic [TW-1:0]   tmo_d;
    logic [2:0]      bit_q;
    logic [3:0]      tx_idx_q;
    logic [3:0]      tx_idx_d;
    logic [7:0]      shift_q;
    logic            par_q;
    logic            second_q;
    logic [6:0]      addr_q;
    logic            rd_dly_q;
    logic [7:0]      txbuf_q;
    logic            tx_q, wr_en_q, rd_en_q, err_q;
    logic [6:0]      wr_addr_q, rd_addr_q;
    logic [7:0]      wr_data_q;
    logic [10:0]     frame_d;
    logic            start_det;
    logic            frame_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign start_det = rx_prev_q & ~rx_s_q;
    assign frame_ok  = ((^shift_q) == par_q) && rx_s_q;
    assign frame_d   = {1'b1, ^txbuf_q, txbuf_q, 1'b0};
    assign tx_idx_d  = tx_idx_q + 4'd1;
    // Saturates so a glitch late in the second-frame wait cannot wrap the timeout.
    assign tmo_d     = (tmo_q < TW'(TMO_CYC)) ? tmo_q + TW'(1) : tmo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            bit_q     <= '0;
            tx_idx_q  <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            second_q  <= 1'b0;
            addr_q    <= '0;
            rd_dly_q  <= 1'b0;
            txbuf_q   <= '0;
            tx_q      <= 1'b1;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_dly_q <= rd_en_q;
            if (rd_dly_q) begin
                txbuf_q <= rd_data;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_det) begin
                        state_q <= S_RX_START;
                        cnt_q   <= '0;
                    end
                end

                S_WAIT2: begin
                    tmo_q <= tmo_d;
                    if (start_det) begin
                        state_q <= S_RX_START;
                        cnt_q   <= '0;
                    end else if (tmo_q >= TW'(TMO_CYC - 1)) begin
                        err_q    <= 1'b1;
                        second_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end

                S_RX_START: begin
                    tmo_q <= tmo_d;
                    if (cnt_q == CW'(HALF - 1)) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= second_q ? S_WAIT2 : S_IDLE;
                        end else begin
                            state_q <= S_RX_DATA;
                            bit_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_RX_DATA: begin
                    if (cnt_q == CW'(BR - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= S_RX_PAR;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_RX_PAR: begin
                    if (cnt_q == CW'(BR - 1)) begin
                        cnt_q   <= '0;
                        par_q   <= rx_s_q;
                        state_q <= S_RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_RX_STOP: begin
                    if (cnt_q == CW'(BR - 1)) begin
                        cnt_q <= '0;
                        if (!frame_ok) begin
                            err_q    <= 1'b1;
                            second_q <= 1'b0;
                            state_q  <= S_IDLE;
                        end else if (second_q) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= shift_q;
                            second_q  <= 1'b0;
                            state_q   <= S_IDLE;
                        end else if (shift_q[7]) begin
                            addr_q   <= shift_q[6:0];
                            second_q <= 1'b1;
                            tmo_q    <= '0;
                            state_q  <= S_WAIT2;
                        end else begin
                            rd_addr_q <= shift_q[6:0];
                            rd_en_q   <= 1'b1;
                            state_q   <= S_TURN;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_TURN: begin
                    if (cnt_q == CW'(TURN_CYC)) begin
                        cnt_q    <= '0;
                        tx_q     <= 1'b0;
                        tx_idx_q <= '0;
                        state_q  <= S_TX;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_TX: begin
                    if (cnt_q == CW'(BR - 1)) begin
                        cnt_q <= '0;
                        if (tx_idx_q == 4'd10) begin
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            tx_idx_q <= tx_idx_d;
                            tx_q     <= frame_d[tx_idx_d];
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx      = tx_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign err     = err_q;

endmodule
